seq_signed_multiplier: RTL and testbench
========================================

Name: seq_signed_multiplier

Overview:
Parametrised iterative multiplier, the sequential successor to the fixed 4-bit combinational signed array multiplier. It accepts WIDTH-bit operands through a valid/ready handshake and computes a 2*WIDTH-bit product, one partial-product row per clock. The signed/unsigned mode is selectable per operation. It sits between operand producers and arithmetic consumers in the datapath and trades latency for area.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), width of the row counter; derived, not overridden.

Ports:
clk  input  1  sole clock, rising edge.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  operands presented.
in_ready  output  1  block can accept operands.
in_a  input  WIDTH  multiplicand.
in_b  input  WIDTH  multiplier.
in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
out_valid  output  1  product available.
out_ready  input  1  consumer accepts the product.
out_product  output  2*WIDTH  product; two's complement when the operation was signed.

Behaviour:
- One clock; reset is synchronous and active-low. When rst_n=0 at a rising edge, the next state is IDLE, in_ready=1, out_valid=0, out_product=0, and the counter and accumulator are cleared. A reset during BUSY or DONE discards the operation.
- States:
  - IDLE: in_ready=1. When in_valid=1 at an edge, latch a, b and signed into registers, clear the accumulator, set count=0 and go to BUSY.
  - BUSY: in_ready=0.
  - DONE: in_ready=0, out_valid=1.
- Each BUSY cycle processes row i=count:
  - Extend the multiplicand to 2*WIDTH bits: sign-extend if signed, zero-extend if not.
  - Row term = b[i] ? (a_ext << i) : 0.
  - For i=WIDTH-1 with signed=1, the row term is subtracted (MSB weight is negative). Otherwise it is added.
  - All arithmetic is modulo 2^(2*WIDTH).
- At the edge where count==WIDTH-1, register the final accumulator into out_product and go to DONE.
- Latency: if the accept handshake happens at edge k, out_valid first rises after edge k+WIDTH.
- DONE: out_product is held stable while out_valid=1 and out_ready=0. On out_valid&out_ready at an edge, go to IDLE and clear out_valid. out_product keeps its value after the handshake until the next completion.
- No new operand is accepted in the cycle the output is consumed; the minimum issue interval is WIDTH+2 cycles.
- in_a, in_b and in_signed are ignored outside the IDLE accept edge. Changes to them during BUSY have no effect.
- Range: 2*WIDTH bits hold every result, including (-2^(W-1))^2 = 2^(2W-2) in signed mode and (2^W-1)^2 in unsigned mode. No overflow flag exists.

Decomposition:
- Package mul_pkg holds:
  - enum state_t {IDLE, BUSY, DONE}.
  - Localparam helpers for the product width (2*WIDTH) and the counter width.
- One sub-module, mul_pp_row (combinational). Inputs: a_ext, b bit, row index, signed, is_last. Output: 2*WIDTH-bit signed row term to be added.
- The top level holds the FSM, counter, accumulator and handshake.

Test Plan:
- WIDTH=4, signed, a=-8, b=-8 -> out_product=0x40 (64); out_valid rises 4 edges after accept.
- WIDTH=4, signed, a=3, b=-5 -> 0xF1 (-15). Signed, a=-8, b=7 -> 0xC8 (-56). Unsigned, a=15, b=15 -> 0xE1 (225).
- WIDTH=4, out_ready held at 0 for 10 cycles after done -> out_valid stays 1, out_product stable, in_ready=0 throughout. Raise out_ready -> IDLE next edge, in_ready=1.
- WIDTH=4, assert rst_n=0 for one edge at count=2 mid-operation -> next cycle out_valid=0, out_product=0, in_ready=1. A following op 2*3 returns 0x06.
- WIDTH=8, signed, a=-128, b=-128 -> 0x4000. Unsigned, a=255, b=255 -> 0xFE01. Latency is 8 edges.
- Randomized check over WIDTH in {2,4,8}, both modes, with random out_ready backpressure, against a reference model. in_a and in_b are toggled during BUSY to confirm they are ignored.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and width helpers for the sequential multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Product width for a given operand width.
    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Row counter width; at least one bit so WIDTH=2 still has a counter.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mul_pp_row.sv
// One partial-product row: the already-extended multiplicand shifted to the
// row position, gated by the multiplier bit, negated for the signed MSB row.
module mul_pp_row
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0]          a_ext,
    input  logic                        b_bit,
    input  logic [cnt_width(WIDTH)-1:0] row,
    input  logic                        is_signed,
    input  logic                        is_last,
    output logic [2*WIDTH-1:0]          term
);

    logic [2*WIDTH-1:0] shifted;

    // Row term is returned already negated when it carries negative weight,
    // so the accumulator only ever adds.
    always_comb begin
        shifted = a_ext << row;
        term    = '0;
        if (b_bit) begin
            if (is_signed && is_last)
                term = -shifted;
            else
                term = shifted;
        end
    end

endmodule

// File: rtl/seq_signed_multiplier.sv
// Iterative signed/unsigned multiplier: one partial-product row per clock,
// valid/ready on both the operand and the product side.
module seq_signed_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product
);

    localparam int PW    = prod_width(WIDTH);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic               signed_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [PW-1:0]      acc_reg;
    logic [PW-1:0]      product_reg;
    logic [PW-1:0]      a_ext;
    logic [PW-1:0]      row_term;
    logic [PW-1:0]      acc_sum;
    logic               last_row;

    assign last_row = (count_reg == CNT_W'(WIDTH - 1));
    assign a_ext    = signed_reg ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg}
                                 : {{WIDTH{1'b0}}, a_reg};
    assign acc_sum  = acc_reg + row_term;

    mul_pp_row #(.WIDTH(WIDTH)) u_pp_row (
        .a_ext     (a_ext),
        .b_bit     (b_reg[count_reg]),
        .row       (count_reg),
        .is_signed (signed_reg),
        .is_last   (last_row),
        .term      (row_term)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic: accept in IDLE, count rows in BUSY, wait for consumer in DONE.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last_row)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, accumulate one row per BUSY cycle,
    // capture the final sum into the output register on the last row.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg       <= '0;
            b_reg       <= '0;
            signed_reg  <= 1'b0;
            count_reg   <= '0;
            acc_reg     <= '0;
            product_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= in_a;
                        b_reg      <= in_b;
                        signed_reg <= in_signed;
                        count_reg  <= '0;
                        acc_reg    <= '0;
                    end
                end
                BUSY: begin
                    acc_reg <= acc_sum;
                    if (last_row)
                        product_reg <= acc_sum;
                    else
                        count_reg <= count_reg + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign out_valid   = (state_reg == DONE);
    assign out_product = product_reg;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Bench for seq_signed_multiplier: three instances (WIDTH 2, 4, 8) on one
// clock, directed corner cases plus randomized operations with backpressure.
module tb_seq_signed_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_signed [3];
    logic        out_ready [3];
    logic [7:0]  in_a      [3];
    logic [7:0]  in_b      [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic [3:0]  p0;
    logic [7:0]  p1;
    logic [15:0] p2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_signed_multiplier #(.WIDTH(2)) dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0][1:0]), .in_b(in_b[0][1:0]), .in_signed(in_signed[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_product(p0)
    );

    seq_signed_multiplier #(.WIDTH(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1][3:0]), .in_b(in_b[1][3:0]), .in_signed(in_signed[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_product(p1)
    );

    seq_signed_multiplier #(.WIDTH(8)) dut_w8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a[2]), .in_b(in_b[2]), .in_signed(in_signed[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_product(p2)
    );

    function automatic int w_of(input int sel);
        return (sel == 0) ? 2 : (sel == 1) ? 4 : 8;
    endfunction

    function automatic logic [15:0] get_prod(input int sel);
        case (sel)
            0:       return {12'd0, p0};
            1:       return {8'd0, p1};
            default: return p2;
        endcase
    endfunction

    // Reference: interpret operands as integers per mode, multiply, wrap.
    function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a,
                                            input logic [7:0] b, input bit sgn);
        longint one = 64'sd1;
        longint ma  = longint'(a) & ((one << w) - 1);
        longint mb  = longint'(b) & ((one << w) - 1);
        longint p;
        if (sgn) begin
            if (ma >= (one << (w - 1))) ma = ma - (one << w);
            if (mb >= (one << (w - 1))) mb = mb - (one << w);
        end
        p = (ma * mb) & ((one << (2 * w)) - 1);
        return 16'(p);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete operation on instance sel: accept, scramble inputs while
    // busy, measure latency, hold backpressure for bp cycles, then consume.
    task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input bit sgn, input int bp, input logic [15:0] expv,
                         input string tag);
        int          n;
        int          w;
        logic [15:0] held;
        w = w_of(sel);
        @(negedge clk);
        check({tag, " in_ready idle"}, 64'(in_ready[sel]), 64'd1);
        in_a[sel]      = a;
        in_b[sel]      = b;
        in_signed[sel] = sgn;
        in_valid[sel]  = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            in_valid[sel]  = 1'b0;
            in_a[sel]      = 8'($urandom);
            in_b[sel]      = 8'($urandom);
            in_signed[sel] = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
            if (out_valid[sel]) break;
        end
        check({tag, " latency"}, 64'(n), 64'(w));
        check({tag, " product"}, 64'(get_prod(sel)), 64'(expv));
        held = get_prod(sel);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, 64'(out_valid[sel]), 64'd1);
            check({tag, " hold ready"}, 64'(in_ready[sel]), 64'd0);
            check({tag, " hold product"}, 64'(get_prod(sel)), 64'(held));
        end
        @(negedge clk);
        out_ready[sel] = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " consumed valid"}, 64'(out_valid[sel]), 64'd0);
        check({tag, " consumed ready"}, 64'(in_ready[sel]), 64'd1);
        check({tag, " product kept"}, 64'(get_prod(sel)), 64'(held));
        @(negedge clk);
        out_ready[sel] = 1'b0;
    endtask

    initial begin
        logic [7:0] ra, rb;
        bit         rs;
        int         rbp;

        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            in_valid[s]  = 1'b0;
            in_signed[s] = 1'b0;
            out_ready[s] = 1'b0;
            in_a[s]      = 8'd0;
            in_b[s]      = 8'd0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check("reset in_ready", 64'(in_ready[s]), 64'd1);
            check("reset out_valid", 64'(out_valid[s]), 64'd0);
            check("reset product", 64'(get_prod(s)), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=4 directed cases.
        do_op(1, 8'h08, 8'h08, 1'b1, 0,  16'h0040, "w4 -8*-8");
        do_op(1, 8'h03, 8'h0B, 1'b1, 1,  16'h00F1, "w4 3*-5");
        do_op(1, 8'h08, 8'h07, 1'b1, 0,  16'h00C8, "w4 -8*7");
        do_op(1, 8'h0F, 8'h0F, 1'b0, 10, 16'h00E1, "w4 15*15 u");

        // Reset at count=2 mid-operation discards it.
        @(negedge clk);
        in_a[1] = 8'h05; in_b[1] = 8'h07; in_signed[1] = 1'b0; in_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset out_valid", 64'(out_valid[1]), 64'd0);
        check("midreset product", 64'(get_prod(1)), 64'd0);
        check("midreset in_ready", 64'(in_ready[1]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1, 8'h02, 8'h03, 1'b0, 0, 16'h0006, "w4 after reset 2*3");

        // WIDTH=8 and WIDTH=2 extremes.
        do_op(2, 8'h80, 8'h80, 1'b1, 0, 16'h4000, "w8 -128*-128");
        do_op(2, 8'hFF, 8'hFF, 1'b0, 2, 16'hFE01, "w8 255*255 u");
        do_op(0, 8'h02, 8'h02, 1'b1, 0, 16'h0004, "w2 -2*-2");
        do_op(0, 8'h03, 8'h03, 1'b0, 0, 16'h0009, "w2 3*3 u");

        // Randomized operations on every width, both modes, random backpressure.
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < 20; k++) begin
                ra  = 8'($urandom);
                rb  = 8'($urandom);
                rs  = 1'($urandom_range(0, 1));
                rbp = $urandom_range(0, 3);
                do_op(s, ra, rb, rs, rbp, ref_mul(w_of(s), ra, rb, rs), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
